// File: rtl/exec_if.sv
// Operand/result bundle between the register group and the execute stage.
// master = register group side (drives operands), slave = exec_unit.
interface exec_if #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
);
    logic                    en_in;
    logic [3:0]              op;
    logic [$clog2(NREG)-1:0] rd;
    logic [WIDTH-1:0]        rd_q;
    logic [WIDTH-1:0]        rs_q;
    logic                    en_out;
    logic [WIDTH-1:0]        d_out;
    logic [NREG-1:0]         reg_en;
    logic                    flag_z;
    logic                    flag_c;
    logic                    flag_n;
    logic                    busy;

    modport master (
        output en_in, op, rd, rd_q, rs_q,
        input  en_out, d_out, reg_en, flag_z, flag_c, flag_n, busy
    );

    modport slave (
        input  en_in, op, rd, rd_q, rs_q,
        output en_out, d_out, reg_en, flag_z, flag_c, flag_n, busy
    );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: single-cycle ALU ops plus a shift-add multiplier.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for en_in; single-cycle ops resolve here
// MUL   | one shift-add iteration per cycle, busy high
// DONE  | en_out pulse cycle; en_in ignored, then back to IDLE
module exec_unit #(
    parameter int WIDTH = 16,
    parameter int NREG  = 4
) (
    input  logic   clk,
    input  logic   rst,
    exec_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(NREG);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MOV = 4'd8;
    localparam logic [3:0] OP_MUL = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               en_out_q, en_out_d;
    logic [WIDTH-1:0]   d_out_q, d_out_d;
    logic [NREG-1:0]    reg_en_q, reg_en_d;
    logic               flag_z_q, flag_z_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_n_q, flag_n_d;
    logic               busy_q, busy_d;
    // Multiplicand and accumulator span the full product so the upper half
    // is available for the MUL carry flag.
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [RW-1:0]      rd_sv_q, rd_sv_d;

    logic [WIDTH:0]     sum_ext, diff_ext;
    logic [2*WIDTH-1:0] acc_sum;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_c, alu_wr, alu_fl;

    assign sum_ext  = {1'b0, bus.rd_q} + {1'b0, bus.rs_q};
    assign diff_ext = {1'b0, bus.rd_q} - {1'b0, bus.rs_q};
    assign acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);

    // Single-cycle ALU result, carry, and whether it writes d_out / flags.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_wr  = 1'b1;
        alu_fl  = 1'b1;
        case (bus.op)
            OP_ADD: begin alu_res = sum_ext[WIDTH-1:0];  alu_c = sum_ext[WIDTH];  end
            OP_SUB: begin alu_res = diff_ext[WIDTH-1:0]; alu_c = diff_ext[WIDTH]; end
            OP_CMP: begin
                alu_res = diff_ext[WIDTH-1:0];
                alu_c   = diff_ext[WIDTH];
                alu_wr  = 1'b0;
            end
            OP_AND: alu_res = bus.rd_q & bus.rs_q;
            OP_OR:  alu_res = bus.rd_q | bus.rs_q;
            OP_XOR: alu_res = bus.rd_q ^ bus.rs_q;
            OP_NOT: alu_res = ~bus.rd_q;
            OP_SHL: begin alu_res = {bus.rd_q[WIDTH-2:0], 1'b0}; alu_c = bus.rd_q[WIDTH-1]; end
            OP_SHR: begin alu_res = {1'b0, bus.rd_q[WIDTH-1:1]}; alu_c = bus.rd_q[0]; end
            OP_MOV: alu_res = bus.rs_q;
            default: begin alu_wr = 1'b0; alu_fl = 1'b0; end
        endcase
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d  = state_q;
        en_out_d = 1'b0;
        reg_en_d = '0;
        d_out_d  = d_out_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        flag_n_d = flag_n_q;
        busy_d   = busy_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        rd_sv_d  = rd_sv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en_in) begin
                    if (bus.op == OP_MUL) begin
                        state_d  = S_MUL;
                        mcand_d  = {{WIDTH{1'b0}}, bus.rd_q};
                        mplier_d = bus.rs_q;
                        acc_d    = '0;
                        cnt_d    = '0;
                        rd_sv_d  = bus.rd;
                        busy_d   = 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        en_out_d = 1'b1;
                        if (alu_wr) begin
                            d_out_d  = alu_res;
                            reg_en_d = NREG'(1) << bus.rd;
                        end
                        if (alu_fl) begin
                            flag_z_d = (alu_res == '0);
                            flag_c_d = alu_c;
                            flag_n_d = alu_res[WIDTH-1];
                        end
                    end
                end
            end
            S_MUL: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    en_out_d = 1'b1;
                    d_out_d  = acc_sum[WIDTH-1:0];
                    reg_en_d = NREG'(1) << rd_sv_q;
                    flag_z_d = (acc_sum[WIDTH-1:0] == '0);
                    flag_c_d = |acc_sum[2*WIDTH-1:WIDTH];
                    flag_n_d = acc_sum[WIDTH-1];
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any MUL in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            en_out_q <= 1'b0;
            d_out_q  <= '0;
            reg_en_q <= '0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
            flag_n_q <= 1'b0;
            busy_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            rd_sv_q  <= '0;
        end else begin
            state_q  <= state_d;
            en_out_q <= en_out_d;
            d_out_q  <= d_out_d;
            reg_en_q <= reg_en_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
            flag_n_q <= flag_n_d;
            busy_q   <= busy_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            rd_sv_q  <= rd_sv_d;
        end
    end

    assign bus.en_out = en_out_q;
    assign bus.d_out  = d_out_q;
    assign bus.reg_en = reg_en_q;
    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;
    assign bus.flag_n = flag_n_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_exec_unit.sv
// Scoreboard bench for exec_unit: stimulus predicts results from plain
// arithmetic, a monitor pops and compares on every en_out.
module tb_exec_unit;
    localparam int W  = 16;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    exec_if #(.WIDTH(W), .NREG(NR)) bus ();
    exec_unit #(.WIDTH(W), .NREG(NR)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [15:0] d;
        logic [3:0]  re;
        logic        z, c, n;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [15:0] m_d = '0;
    logic m_z = 1'b0, m_c = 1'b0, m_n = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: result from the operation's arithmetic meaning.
    task automatic predict(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                           input logic [1:0] rd, input int when);
        logic [31:0] p;
        logic [15:0] r;
        logic c;
        bit wr, fl;
        exp_t x;
        p = '0; r = '0; c = 1'b0; wr = 1; fl = 1;
        case (op)
            4'd0: begin p = 32'(a) + 32'(b); r = p[15:0]; c = p[16]; end
            4'd1: begin r = a - b; c = (a < b); end
            4'd10: begin r = a - b; c = (a < b); wr = 0; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = 16'hFFFF - a;
            4'd6: begin p = 32'(a) * 2; r = p[15:0]; c = p[16]; end
            4'd7: begin r = a / 2; c = (a % 2) != 0; end
            4'd8: r = b;
            4'd9: begin p = 32'(a) * 32'(b); r = p[15:0]; c = (p / 65536) != 0; end
            default: begin wr = 0; fl = 0; end
        endcase
        if (wr) m_d = r;
        if (fl) begin m_z = (r == 16'd0); m_c = c; m_n = (r >= 16'h8000); end
        x.d = m_d; x.z = m_z; x.c = m_c; x.n = m_n; x.cyc = when;
        x.re = wr ? (4'b0001 << rd) : 4'b0000;
        q.push_back(x);
    endtask

    // Monitor: compare every result strobe against the scoreboard head.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            if (bus.en_out) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_en_out: got en_out=1 at cycle %0d expected none", cyc);
                end else begin
                    e = q.pop_front();
                    check("d_out",   32'(bus.d_out),  32'(e.d));
                    check("reg_en",  32'(bus.reg_en), 32'(e.re));
                    check("flag_z",  32'(bus.flag_z), 32'(e.z));
                    check("flag_c",  32'(bus.flag_c), 32'(e.c));
                    check("flag_n",  32'(bus.flag_n), 32'(e.n));
                    check("latency", cyc, e.cyc);
                end
            end else begin
                check("reg_en_idle", 32'(bus.reg_en), 32'd0);
            end
        end
    end

    // Issue one op at a negedge; optionally inject an ADD or a reset at the
    // given busy cycle of a MUL. Returns at a negedge with the unit idle.
    task automatic do_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic [1:0] rd, input int intr_at, input int rst_at);
        int bsy;
        bit aborted;
        bsy = 0;
        aborted = 0;
        bus.en_in = 1'b1; bus.op = op; bus.rd = rd; bus.rd_q = a; bus.rs_q = b;
        if (rst_at == 0) predict(op, a, b, rd, cyc + 1 + ((op == 4'd9) ? W : 0));
        @(negedge clk);
        bus.en_in = 1'b0;
        bus.rd_q = 16'($urandom);
        bus.rs_q = 16'($urandom);
        while (bus.busy && bsy < 40) begin
            bsy++;
            if (bsy == rst_at) begin
                rst = 1'b0;
                #1;
                check("reset_outputs",
                      32'({bus.en_out, bus.d_out, bus.reg_en, bus.flag_z, bus.flag_c, bus.flag_n, bus.busy}),
                      32'd0);
                m_d = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                aborted = 1;
                break;
            end
            if (bsy == intr_at) begin
                bus.en_in = 1'b1; bus.op = 4'd0; bus.rd = 2'($urandom);
            end
            @(negedge clk);
            bus.en_in = 1'b0;
        end
        if (aborted) begin
            repeat (3) @(negedge clk);
        end else begin
            check("busy_cycles", bsy, (op == 4'd9) ? W : 0);
            @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] op;
        logic [15:0] a, b;
        bus.en_in = 1'b0; bus.op = '0; bus.rd = '0; bus.rd_q = '0; bus.rs_q = '0;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state",
              32'({bus.en_out, bus.d_out, bus.reg_en, bus.flag_z, bus.flag_c, bus.flag_n, bus.busy}),
              32'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(4'd0,  16'hFFFF, 16'h0001, 2'd2, 0, 0);
        do_op(4'd1,  16'h0003, 16'h0005, 2'd1, 0, 0);
        do_op(4'd10, 16'h0005, 16'h0005, 2'd0, 0, 0);
        do_op(4'd9,  16'h0123, 16'h0010, 2'd3, 0, 0);
        do_op(4'd9,  16'h8000, 16'h0002, 2'd0, 0, 0);
        do_op(4'd9,  16'h0F0F, 16'h1234, 2'd1, 5, 0);
        do_op(4'd9,  16'h00FF, 16'h00FF, 2'd2, 0, 8);
        do_op(4'd6,  16'h8001, 16'h0000, 2'd0, 0, 0);
        do_op(4'd12, 16'h1111, 16'h2222, 2'd3, 0, 0);

        // en_in held high: accepted every other cycle
        bus.en_in = 1'b1; bus.op = 4'd0; bus.rd = 2'd1; bus.rd_q = 16'h1000; bus.rs_q = 16'h0234;
        predict(4'd0, 16'h1000, 16'h0234, 2'd1, cyc + 1);
        @(negedge clk);
        @(negedge clk);
        bus.rd_q = 16'h8000; bus.rs_q = 16'h8000;
        predict(4'd0, 16'h8000, 16'h8000, 2'd1, cyc + 1);
        @(negedge clk);
        @(negedge clk);
        bus.en_in = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = 16'($urandom);
            b  = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            if ($urandom_range(0, 4) == 0) a = 16'h8000 | 16'($urandom_range(0, 1));
            do_op(op, a, b, 2'($urandom), 0, 0);
        end

        repeat (4) @(negedge clk);
        check("queue_empty", q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
